hex_display_ctrl: RTL and testbench

Parametrised multi-digit seven-segment display controller driving NDIGITS active-low HEX digits of the board. It holds a value loaded by strobe and presents it in one of four modes: static, blink, scroll (rotate) or free-running count. A tick prescaler paces the animated modes. Optional leading-zero blanking is supported. It sits between board-level user logic (switches/keys) and the hex outputs, and replaces per-digit decoder instances.

---
 rtl/hex_display_ctrl.sv | 133 +++++++++++++
 tb/tb_hex_display_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low seven-segment controller: holds a loaded value and shows it
// static, blinking, rotating or free-running-counting, paced by a tick prescaler.
module hex_display_ctrl #(
    parameter int NDIGITS  = 6,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [1:0]             mode,
    input  logic                   blank_lz,
    output logic [7*NDIGITS-1:0]   seg,
    output logic                   tick
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int OW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    generate
        if (TICK_DIV < 2 || NDIGITS < 1 || NDIGITS > 8) begin : g_bad_params
            $error("hex_display_ctrl: unsupported NDIGITS or TICK_DIV");
        end
    endgenerate

    logic [W-1:0]         r_val;
    logic [CW-1:0]        r_cnt;
    logic [OW-1:0]        r_offset;
    logic                 r_phase;
    logic [1:0]           r_mode;
    logic                 r_blz;
    logic                 r_tick;
    logic [7*NDIGITS-1:0] r_seg;

    logic                 w_clear;
    logic                 w_wrap;
    logic                 w_tick_evt;
    logic [2*W-1:0]       w_dbl_rot;
    logic [W-1:0]         w_disp_val;
    logic                 w_blink_off;
    logic                 w_lz_en;
    logic [7*NDIGITS-1:0] w_seg_next;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_clear    = load | (mode != r_mode);
    assign w_wrap     = (r_cnt == CW'(TICK_DIV - 1));
    assign w_tick_evt = w_wrap & ~w_clear;

    // Upper half of the doubled value shifted left by offset digits is the rotated value.
    assign w_dbl_rot   = {r_val, r_val} << {r_offset, 2'b00};
    assign w_disp_val  = (r_mode == MODE_SCROLL) ? w_dbl_rot[2*W-1:W] : r_val;
    assign w_blink_off = (r_mode == MODE_BLINK) && !r_phase;
    assign w_lz_en     = r_blz && (r_mode != MODE_SCROLL);

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
            logic w_upper_zero;
            logic w_blank;
            assign w_upper_zero = (w_disp_val[W-1:4*gi] == '0);
            assign w_blank      = w_blink_off || (w_lz_en && (gi != 0) && w_upper_zero);
            assign w_seg_next[7*gi +: 7] = w_blank ? 7'h7F : f_decode(w_disp_val[4*gi +: 4]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_val    <= '0;
            r_cnt    <= '0;
            r_offset <= '0;
            r_phase  <= 1'b1;
            r_mode   <= MODE_STATIC;
            r_blz    <= 1'b0;
            r_tick   <= 1'b0;
            r_seg    <= '1;
        end else begin
            r_seg  <= w_seg_next;
            r_mode <= mode;
            r_blz  <= blank_lz;
            r_tick <= w_tick_evt;
            if (w_clear) begin
                r_cnt    <= '0;
                r_offset <= '0;
                r_phase  <= 1'b1;
                if (load) begin
                    r_val <= value;
                end
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
                if (w_wrap) begin
                    case (r_mode)
                        MODE_BLINK:  r_phase <= ~r_phase;
                        MODE_SCROLL: r_offset <= (r_offset == OW'(NDIGITS - 1)) ? '0
                                                                                : r_offset + 1'b1;
                        MODE_COUNT:  r_val <= r_val + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign seg  = r_seg;
    assign tick = r_tick;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: directed scenarios plus random traffic, checked every
// cycle against a model that tracks loaded value and edges elapsed since the last clear.
module tb_hex_display_ctrl;

    localparam int ND = 6;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [23:0]   value = '0;
    logic [1:0]    mode = 2'b00;
    logic          blank_lz = 1'b0;
    logic [41:0]   seg;
    logic          tick;

    int total = 0;
    int bad = 0;

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: value at last clear, edges since last clear, registered mode/blank_lz.
    logic [23:0] m_base = '0;
    int          m_c = 0;
    logic [1:0]  m_mode = 2'b00;
    logic        m_blz = 1'b0;

    hex_display_ctrl #(.NDIGITS(ND), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .seg      (seg),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] m_val();
        if (m_mode == 2'b11) return m_base + 24'(m_c / TD);
        return m_base;
    endfunction

    function automatic logic [41:0] render();
        logic [41:0] r;
        logic [23:0] v;
        logic [3:0]  nib [ND];
        logic [3:0]  shown [ND];
        int k, msd;
        logic blank;
        v = m_val();
        k = m_c / TD;
        for (int p = 0; p < ND; p++) nib[p] = v[4*p +: 4];
        for (int p = 0; p < ND; p++)
            shown[p] = (m_mode == 2'b10) ? nib[(p - (k % ND) + ND) % ND] : nib[p];
        msd = 0;
        for (int p = 0; p < ND; p++) if (shown[p] != 4'h0) msd = p;
        for (int p = 0; p < ND; p++) begin
            blank = ((m_mode == 2'b01) && (k % 2 == 1)) ||
                    (m_blz && (m_mode != 2'b10) && (p > msd));
            r[7*p +: 7] = blank ? 7'h7F : dec_tab[shown[p]];
        end
        return r;
    endfunction

    task automatic step(input logic l, input logic [23:0] v, input logic [1:0] m,
                        input logic b, input logic rn);
        logic [41:0] es;
        logic        et;
        logic        clr;
        load = l; value = v; mode = m; blank_lz = b; reset_n = rn;
        clr = 1'b0;
        if (!rn) begin
            es = '1;
            et = 1'b0;
        end else begin
            es  = render();
            clr = l || (m != m_mode);
            et  = !clr && (m_c % TD == TD - 1);
        end
        @(posedge clk);
        if (!rn) begin
            m_base = '0; m_c = 0; m_mode = 2'b00; m_blz = 1'b0;
        end else begin
            if (clr) begin
                m_base = l ? v : m_val();
                m_c    = 0;
                m_mode = m;
            end else begin
                m_c++;
            end
            m_blz = b;
        end
        #1;
        chk("seg", {22'd0, seg}, {22'd0, es});
        chk("tick", {63'd0, tick}, {63'd0, et});
        if (l && rn) $display("load value=%h mode=%0d blz=%0d seg=%h", v, m, b, seg);
    endtask

    task automatic idle(input int n, input logic [1:0] m, input logic b);
        for (int i = 0; i < n; i++) step(1'b0, 24'h0, m, b, 1'b1);
    endtask

    initial begin
        logic [6:0]  exp_dig [6];
        logic [23:0] rv;
        logic [1:0]  rm;
        logic        rb;

        // Reset and idle
        step(1'b0, 24'h0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 24'h0, 2'b00, 1'b0, 1'b0);
        chk("reset_seg", {22'd0, seg}, {22'd0, 42'h3FF_FFFF_FFFF});
        idle(2, 2'b00, 1'b0);
        for (int p = 0; p < ND; p++) chk("idle_zero", {57'd0, seg[7*p +: 7]}, 64'h40);

        // Static decode
        step(1'b1, 24'h12AB34, 2'b00, 1'b0, 1'b1);
        idle(1, 2'b00, 1'b0);
        exp_dig = '{7'h19, 7'h30, 7'h03, 7'h08, 7'h24, 7'h79};
        for (int p = 0; p < ND; p++) chk("static_dig", {57'd0, seg[7*p +: 7]}, {57'd0, exp_dig[p]});
        idle(10, 2'b00, 1'b0);

        // Leading-zero blanking, then scroll ignores it
        step(1'b1, 24'h000305, 2'b00, 1'b1, 1'b1);
        idle(3, 2'b00, 1'b1);
        step(1'b1, 24'h000000, 2'b00, 1'b1, 1'b1);
        idle(3, 2'b00, 1'b1);
        idle(3, 2'b10, 1'b1);

        // Blink, with a load mid-blank
        step(1'b1, 24'h000001, 2'b01, 1'b0, 1'b1);
        idle(14, 2'b01, 1'b0);
        step(1'b1, 24'h000002, 2'b01, 1'b0, 1'b1);
        idle(10, 2'b01, 1'b0);

        // Scroll through a full rotation, then back to static
        step(1'b1, 24'h012345, 2'b10, 1'b0, 1'b1);
        idle(TD * ND + 6, 2'b10, 1'b0);
        idle(3, 2'b00, 1'b0);

        // Count wrap, and load colliding with a tick
        step(1'b1, 24'hFFFFFE, 2'b11, 1'b0, 1'b1);
        idle(TD * 2 + 2, 2'b11, 1'b0);
        for (int p = 0; p < ND; p++) chk("count_wrap", {57'd0, seg[7*p +: 7]}, 64'h40);
        step(1'b1, 24'hFFFFFE, 2'b11, 1'b0, 1'b1);
        idle(TD - 1, 2'b11, 1'b0);
        step(1'b1, 24'h000010, 2'b11, 1'b0, 1'b1);
        idle(TD + 2, 2'b11, 1'b0);

        // Random traffic, including occasional mid-animation resets
        rm = 2'b00;
        rb = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) rb = ~rb;
            rv = 24'($urandom) >> $urandom_range(0, 23);
            step($urandom_range(0, 9) == 0, rv, rm, rb, $urandom_range(0, 199) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
